// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM CPU scheduler.
// Command kinds, FSM states, bus widths and the byte-strobe mapping.
package sdram_pkg;

    localparam int SD_AW        = 21;
    localparam int SD_DW        = 32;
    localparam int EDGE_TIMEOUT = 4;

    typedef enum logic [1:0] {
        KIND_RD,
        KIND_WR,
        KIND_REF
    } kind_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // A 16-bit CPU word sits in the upper or lower half of the
    // 32-bit SDRAM word depending on the CPU word address LSB.
    function automatic logic [3:0] map_ds(
        input logic a0,
        input logic uds,
        input logic lds
    );
        return a0 ? {uds, lds, 2'b00} : {2'b00, uds, lds};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator for the SDRAM scheduler.
// Ports: clk, reset (sync, high), clear (refresh taken), pending (request).
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(REFRESH_CYCLES - 1));

    // A wrap while already pending is simply absorbed; a wrap in the
    // same cycle as a clear starts a fresh request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_cpu_sched.sv
// Converts 16-bit 68000-style CPU cycles and periodic refreshes into
// single cs-edge SDRAM commands. Ports: cpu_* (CPU side), sd_* (controller).
module sdram_cpu_sched
    import sdram_pkg::*;
#(
    parameter int REFRESH_CYCLES = 250,
    parameter int CPU_AW         = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic              cpu_uds,
    input  logic              cpu_lds,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_ack,
    input  logic              sd_ready,
    input  logic              sd_cmd_ready,
    output logic              sd_cs,
    output logic              sd_we,
    output logic              sd_refresh,
    output logic [SD_AW-1:0]  sd_addr,
    output logic [3:0]        sd_ds,
    output logic [SD_DW-1:0]  sd_din,
    input  logic [SD_DW-1:0]  sd_dout,
    input  logic              sd_dout_valid
);

    localparam int TW = $clog2(EDGE_TIMEOUT);

    state_t        state;
    state_t        state_n;
    kind_t         kind;
    logic [TW-1:0] tmo;
    logic          a0;
    logic          ack_ok;
    logic          ref_pending;
    logic          ref_clear;
    logic          take_ref;
    logic          take_cpu;
    logic          tmo_inc;
    logic          rd_done;
    logic          wr_done;
    logic          cs_n;

    sdram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (ref_clear),
        .pending(ref_pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        take_ref  = 1'b0;
        take_cpu  = 1'b0;
        tmo_inc   = 1'b0;
        ref_clear = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (sd_ready && sd_cmd_ready) begin
                    if (ref_pending) begin
                        take_ref = 1'b1;
                        state_n  = S_ISSUE;
                    end else if (cpu_req) begin
                        take_cpu = 1'b1;
                        state_n  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // The refresh request is only retired once the controller
                // has seen the edge, so a lost edge reissues it.
                if (!sd_cmd_ready) begin
                    state_n   = S_WAIT_DONE;
                    ref_clear = (kind == KIND_REF);
                end else if (tmo == TW'(EDGE_TIMEOUT - 1)) begin
                    state_n = S_GAP;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                unique case (kind)
                    KIND_RD: begin
                        if (sd_dout_valid) begin
                            rd_done = 1'b1;
                            state_n = S_GAP;
                        end
                    end
                    KIND_WR: begin
                        if (sd_cmd_ready) begin
                            wr_done = 1'b1;
                            state_n = S_GAP;
                        end
                    end
                    default: begin
                        if (sd_cmd_ready) begin
                            state_n = S_GAP;
                        end
                    end
                endcase
            end
            S_GAP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // cs is registered from the next state so the controller sees a
    // clean, glitch-free edge; GAP and IDLE both hold it low.
    assign cs_n = (state_n == S_ISSUE) ||
                  (state_n == S_WAIT_BUSY) ||
                  (state_n == S_WAIT_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            kind       <= KIND_RD;
            tmo        <= '0;
            a0         <= 1'b0;
            ack_ok     <= 1'b0;
            sd_cs      <= 1'b0;
            sd_we      <= 1'b0;
            sd_refresh <= 1'b0;
            sd_addr    <= '0;
            sd_ds      <= '0;
            sd_din     <= '0;
            cpu_dout   <= '0;
            cpu_ack    <= 1'b0;
        end else begin
            sd_cs   <= cs_n;
            cpu_ack <= 1'b0;
            // Once the CPU abandons the cycle its ack is never delivered.
            if (!cpu_req) begin
                ack_ok <= 1'b0;
            end
            if (take_ref) begin
                kind       <= KIND_REF;
                sd_refresh <= 1'b1;
                sd_we      <= 1'b0;
                tmo        <= '0;
            end
            if (take_cpu) begin
                kind       <= cpu_we ? KIND_WR : KIND_RD;
                sd_refresh <= 1'b0;
                sd_we      <= cpu_we;
                sd_addr    <= cpu_addr[CPU_AW-1:1];
                sd_ds      <= map_ds(cpu_addr[0], cpu_uds, cpu_lds);
                sd_din     <= {cpu_din, cpu_din};
                a0         <= cpu_addr[0];
                ack_ok     <= 1'b1;
                tmo        <= '0;
            end
            if (tmo_inc) begin
                tmo <= tmo + TW'(1);
            end
            if (rd_done) begin
                cpu_dout <= a0 ? sd_dout[31:16] : sd_dout[15:0];
                cpu_ack  <= ack_ok && cpu_req;
            end
            if (wr_done) begin
                cpu_ack <= ack_ok && cpu_req;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cpu_sched.sv
// Self-checking bench for sdram_cpu_sched with a behavioural controller.
// Table vectors, random traffic vs a 16-bit memory model, corner sequences.
`timescale 1ns/1ps
module tb_sdram_cpu_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic        cpu_uds = 1'b0;
    logic        cpu_lds = 1'b0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic        sd_ready = 1'b0;
    logic        sd_cmd_ready = 1'b1;
    logic        sd_cs;
    logic        sd_we;
    logic        sd_refresh;
    logic [20:0] sd_addr;
    logic [3:0]  sd_ds;
    logic [31:0] sd_din;
    logic [31:0] sd_dout = '0;
    logic        sd_dout_valid = 1'b0;

    sdram_cpu_sched dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_uds      (cpu_uds),
        .cpu_lds      (cpu_lds),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .cpu_ack      (cpu_ack),
        .sd_ready     (sd_ready),
        .sd_cmd_ready (sd_cmd_ready),
        .sd_cs        (sd_cs),
        .sd_we        (sd_we),
        .sd_refresh   (sd_refresh),
        .sd_addr      (sd_addr),
        .sd_ds        (sd_ds),
        .sd_din       (sd_din),
        .sd_dout      (sd_dout),
        .sd_dout_valid(sd_dout_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        bit          is_ref;
        bit          we;
        logic [20:0] addr;
        logic [3:0]  ds;
        logic [31:0] din;
    } edge_t;

    logic [31:0] mem [int];
    logic [15:0] ref16 [int];
    edge_t       edges [$];
    edge_t       last_cpu;
    int          prev_cpu_cyc = 0;
    int          cpu_edges = 0;
    int          acks = 0;
    int          last_ack_cyc = 0;
    int          low_run = 100;
    int          ignore_edges = 0;
    int          lat_rd = 6;
    int          lat_wr = 4;
    int          lat_ref = 4;
    bit          busy = 0;
    int          cnt = 0;
    edge_t       cur;
    logic        cs_prev = 1'b0;

    function automatic logic [31:0] rd_mem(input int a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Controller model and bus monitor, both on the falling edge.
    always @(negedge clk) begin
        edge_t       e;
        logic [31:0] w;
        sd_dout_valid = 1'b0;
        if (cpu_ack) begin
            acks++;
            last_ack_cyc = cyc;
            chk("ack_with_req", cpu_req, 1);
        end
        if (sd_cs && !cs_prev) begin
            e = '{cyc, sd_refresh, sd_we, sd_addr, sd_ds, sd_din};
            edges.push_back(e);
            chk("cs_low_gap", (low_run >= 2), 1);
            if (sd_refresh) begin
                chk("ref_we_low", sd_we, 0);
            end else begin
                prev_cpu_cyc = last_cpu.cyc;
                last_cpu = e;
                cpu_edges++;
            end
        end
        low_run = sd_cs ? 0 : low_run + 1;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                busy = 0;
                sd_cmd_ready = 1'b1;
                if (!cur.is_ref && !cur.we) begin
                    sd_dout = rd_mem(int'(cur.addr));
                    sd_dout_valid = 1'b1;
                end else if (!cur.is_ref) begin
                    w = rd_mem(int'(cur.addr));
                    for (int b = 0; b < 4; b++)
                        if (cur.ds[b]) w[b*8 +: 8] = cur.din[b*8 +: 8];
                    mem[int'(cur.addr)] = w;
                end
            end
        end else if (sd_cs && !cs_prev) begin
            if (ignore_edges > 0) begin
                ignore_edges--;
            end else begin
                busy = 1;
                sd_cmd_ready = 1'b0;
                cur = e;
                cnt = e.is_ref ? lat_ref : (e.we ? lat_wr : lat_rd);
            end
        end
        cs_prev = sd_cs;
    end

    task automatic cpu_cycle(input bit we, input logic [21:0] a,
                             input bit u, input bit l,
                             input logic [15:0] d,
                             output logic [15:0] dout,
                             output int nack, output int ecnt);
        int a0 = acks;
        int e0 = cpu_edges;
        int n = 0;
        @(negedge clk); #1;
        cpu_we = we; cpu_addr = a; cpu_uds = u; cpu_lds = l;
        cpu_din = d; cpu_req = 1'b1;
        while (!cpu_ack && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ack_timeout", (n < 200), 1);
        dout = cpu_dout;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        nack = acks - a0;
        ecnt = cpu_edges - e0;
    endtask

    task automatic do_reset();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [21:0] addr;
        bit          u;
        bit          l;
        logic [15:0] din;
        logic [31:0] pre;
        logic [20:0] e_addr;
        logic [3:0]  e_ds;
        logic [31:0] e_din;
        logic [15:0] e_dout;
        logic [31:0] e_mem;
    } vec_t;

    initial begin
        vec_t        tv [7];
        logic [15:0] dout;
        int          nack, ecnt, e0, a0, n, r, d;
        int          rc [$];

        tv[0] = '{0, 22'h000005, 1, 1, 16'h0, 32'hDEADBEEF,
                  21'h000002, 4'b1100, 32'h0, 16'hDEAD, 32'h0};
        tv[1] = '{0, 22'h000004, 1, 1, 16'h0, 32'hDEADBEEF,
                  21'h000002, 4'b0011, 32'h0, 16'hBEEF, 32'h0};
        tv[2] = '{1, 22'h000004, 0, 1, 16'h00A5, 32'h11223344,
                  21'h000002, 4'b0001, 32'h00A500A5, 16'h0, 32'h112233A5};
        tv[3] = '{1, 22'h000003, 1, 0, 16'h1234, 32'h0,
                  21'h000001, 4'b1000, 32'h12341234, 16'h0, 32'h12000000};
        tv[4] = '{0, 22'h3FFFFF, 1, 0, 16'h0, 32'hCAFEF00D,
                  21'h1FFFFF, 4'b1000, 32'h0, 16'hCAFE, 32'h0};
        tv[5] = '{1, 22'h3FFFFE, 1, 1, 16'h5A5A, 32'hFFFFFFFF,
                  21'h1FFFFF, 4'b0011, 32'h5A5A5A5A, 16'h0, 32'hFFFF5A5A};
        tv[6] = '{0, 22'h000000, 0, 1, 16'h0, 32'h00008001,
                  21'h000000, 4'b0001, 32'h0, 16'h8001, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs", sd_cs, 0);
        chk("rst_we", sd_we, 0);
        chk("rst_refresh", sd_refresh, 0);
        chk("rst_addr", sd_addr, 0);
        chk("rst_ds", sd_ds, 0);
        chk("rst_din", sd_din, 0);
        chk("rst_dout", cpu_dout, 0);
        chk("rst_ack", cpu_ack, 0);
        #1 reset = 1'b0;
        sd_ready = 1'b1;

        // Lost edge: first edge ignored, retry after the timeout
        mem[2] = 32'hDEADBEEF;
        ignore_edges = 1;
        cpu_cycle(0, 22'h000005, 1, 1, 16'h0, dout, nack, ecnt);
        chk("lost_edges", ecnt, 2);
        chk("lost_retry_gap", last_cpu.cyc - prev_cpu_cyc, 7);
        chk("lost_ack", nack, 1);
        chk("lost_ack_after_retry", (last_ack_cyc > last_cpu.cyc), 1);
        chk("lost_dout", dout, 16'hDEAD);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            mem[int'(tv[i].e_addr)] = tv[i].pre;
            cpu_cycle(tv[i].we, tv[i].addr, tv[i].u, tv[i].l, tv[i].din,
                      dout, nack, ecnt);
            chk("tv_ack", nack, 1);
            chk("tv_edges", ecnt, 1);
            chk("tv_addr", last_cpu.addr, tv[i].e_addr);
            chk("tv_ds", last_cpu.ds, tv[i].e_ds);
            chk("tv_we", last_cpu.we, tv[i].we);
            if (tv[i].we) begin
                chk("tv_din", last_cpu.din, tv[i].e_din);
                chk("tv_mem", rd_mem(int'(tv[i].e_addr)), tv[i].e_mem);
            end else begin
                chk("tv_dout", dout, tv[i].e_dout);
            end
        end

        // CPU drops the request mid-write: command completes, no ack
        a0 = acks;
        e0 = cpu_edges;
        @(negedge clk); #1;
        cpu_we = 1; cpu_addr = 22'h000010; cpu_uds = 1; cpu_lds = 1;
        cpu_din = 16'hBEEF; cpu_req = 1'b1;
        n = 0;
        while (cpu_edges == e0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drop_edge_seen", (cpu_edges > e0), 1);
        cpu_req = 1'b0;
        repeat (15) @(negedge clk);
        chk("drop_no_ack", acks - a0, 0);
        chk("drop_mem", rd_mem(8) & 32'hFFFF, 32'hBEEF);

        // Random traffic against a 16-bit CPU-view memory model
        for (int i = 0; i < 150; i++) begin
            bit          we, u, l;
            logic [21:0] a;
            logic [15:0] dd;
            logic [3:0]  eds;
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            a  = 22'h100 + 22'($urandom_range(0, 31));
            dd = 16'($urandom);
            lat_rd = $urandom_range(2, 7);
            lat_wr = $urandom_range(2, 6);
            cpu_cycle(we, a, u, l, dd, dout, nack, ecnt);
            eds = 4'({u, l}) << (a[0] ? 2 : 0);
            chk("rnd_ack", nack, 1);
            chk("rnd_addr", last_cpu.addr, a / 2);
            chk("rnd_ds", last_cpu.ds, eds);
            if (we) begin
                logic [15:0] o;
                o = ref16.exists(int'(a)) ? ref16[int'(a)] : 16'h0;
                if (u) o[15:8] = dd[15:8];
                if (l) o[7:0] = dd[7:0];
                ref16[int'(a)] = o;
                chk("rnd_din", last_cpu.din, {dd, dd});
            end else begin
                chk("rnd_rd", dout,
                    ref16.exists(int'(a)) ? ref16[int'(a)] : 16'h0);
            end
        end
        lat_rd = 6;
        lat_wr = 4;

        // Reset while a read is in WAIT_DONE
        mem[2] = 32'hDEADBEEF;
        a0 = acks;
        e0 = cpu_edges;
        @(negedge clk); #1;
        cpu_we = 0; cpu_addr = 22'h000005; cpu_uds = 1; cpu_lds = 1;
        cpu_req = 1'b1;
        n = 0;
        while (cpu_edges == e0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rstop_edge_seen", (cpu_edges > e0), 1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk); #1;
        chk("rstop_cs", sd_cs, 0);
        chk("rstop_outs", {sd_we, sd_refresh, sd_addr, sd_ds, cpu_ack}, 0);
        chk("rstop_data", {sd_din, cpu_dout}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstop_no_ack", acks - a0, 0);
        cpu_cycle(0, 22'h000005, 1, 1, 16'h0, dout, nack, ecnt);
        chk("rstop_after_ack", nack, 1);
        chk("rstop_after_dout", dout, 16'hDEAD);

        // Refresh cadence with no CPU traffic
        do_reset();
        r = cyc;
        e0 = edges.size();
        a0 = acks;
        repeat (800) @(negedge clk);
        for (int i = e0; i < edges.size(); i++)
            if (edges[i].is_ref) rc.push_back(edges[i].cyc);
        chk("cad_count", (rc.size() >= 3), 1);
        chk("cad_all_ref", edges.size() - e0, rc.size());
        chk("cad_no_ack", acks - a0, 0);
        if (rc.size() >= 3) begin
            d = rc[0] - r - 250;
            chk("cad_first", (d >= -8 && d <= 8), 1);
            for (int k = 1; k < 3; k++) begin
                d = rc[k] - rc[k-1] - 250;
                chk("cad_interval", (d >= -8 && d <= 8), 1);
            end
        end

        // Wraps while unready collapse into a single refresh
        sd_ready = 1'b0;
        do_reset();
        e0 = edges.size();
        repeat (600) @(negedge clk);
        chk("unready_no_edge", edges.size() - e0, 0);
        #1 sd_ready = 1'b1;
        repeat (100) @(negedge clk);
        chk("absorb_single", edges.size() - e0, 1);

        // Refresh and CPU read requested in the same IDLE cycle
        mem[2] = 32'hDEADBEEF;
        sd_ready = 1'b0;
        do_reset();
        e0 = edges.size();
        a0 = acks;
        cpu_we = 0; cpu_addr = 22'h000005; cpu_uds = 1; cpu_lds = 1;
        cpu_req = 1'b1;
        repeat (270) @(negedge clk);
        #1 sd_ready = 1'b1;
        n = 0;
        while (!cpu_ack && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("sim_ack_timeout", (n < 100), 1);
        dout = cpu_dout;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sim_edges", edges.size() - e0, 2);
        if (edges.size() - e0 >= 2) begin
            chk("sim_first_ref", edges[e0].is_ref, 1);
            chk("sim_second_cpu", edges[e0+1].is_ref, 0);
        end
        chk("sim_acks", acks - a0, 1);
        chk("sim_dout", dout, 16'hDEAD);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_cpu_sched.md
Name: sdram_cpu_sched

Overview:
- Upstream request scheduler for the 32-bit SDRAM controller on the Tang Nano 20k NKC_68k16 build.
- Accepts 16-bit 68000-style bus cycles and converts them into single cs-edge-triggered SDRAM commands with 32-bit data and 4-bit byte strobes.
- Generates periodic auto-refresh requests and arbitrates them against CPU cycles.
- Returns read data and a one-cycle acknowledge to the CPU.

Parameters:
- REFRESH_CYCLES, 250, clk cycles between refresh requests (7.8 us at 32 MHz).
- CPU_AW, 22, CPU 16-bit word address width. SDRAM word address is CPU_AW-1 = 21 bits.

Ports:
- clk, in, 1, single system clock, same clock as the SDRAM controller.
- reset, in, 1, synchronous active-high reset.
- cpu_req, in, 1, CPU cycle request (level), held until cpu_ack.
- cpu_we, in, 1, 1 = write; stable while cpu_req is high.
- cpu_addr, in, 22, 16-bit word address.
- cpu_uds, in, 1, upper byte strobe (active high).
- cpu_lds, in, 1, lower byte strobe (active high).
- cpu_din, in, 16, write data.
- cpu_dout, out, 16, read data; valid when cpu_ack is high on a read.
- cpu_ack, out, 1, one-cycle completion pulse.
- sd_ready, in, 1, controller initialised.
- sd_cmd_ready, in, 1, controller idle and accepting a command.
- sd_cs, out, 1, command request; the controller acts on its rising edge.
- sd_we, out, 1, write select.
- sd_refresh, out, 1, refresh select, qualified by the sd_cs edge.
- sd_addr, out, 21, SDRAM 32-bit word address.
- sd_ds, out, 4, byte enables, active high.
- sd_din, out, 32, write data.
- sd_dout, in, 32, read data.
- sd_dout_valid, in, 1, read data strobe.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; refresh counter 0; refresh_pending 0.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 and wraps.
  - At wrap, sets refresh_pending.
  - refresh_pending clears when a refresh is issued.
  - A wrap while refresh_pending is already set is absorbed (no second pending refresh).
  - The timer runs regardless of sd_ready.
- Address and data mapping, registered at ISSUE:
  - sd_addr = cpu_addr[21:1].
  - sd_ds = cpu_addr[0] ? {cpu_uds,cpu_lds,2'b00} : {2'b00,cpu_uds,cpu_lds}.
  - sd_din = {cpu_din,cpu_din}.
  - Read return: cpu_dout = half of sd_dout selected by the latched cpu_addr[0]; 1 selects [31:16].
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: waits for sd_ready && sd_cmd_ready.
  - If refresh_pending: refresh has priority. Latch kind=REF, set sd_refresh=1, sd_we=0, go to ISSUE.
  - Else if cpu_req: latch kind=RD or WR, drive the mapped outputs, sd_refresh=0, go to ISSUE.
  - sd_cs=0 throughout.
- ISSUE: sd_cs=1 for this cycle, then go to WAIT_BUSY. sd_cs stays high until GAP.
- WAIT_BUSY:
  - Stay until sd_cmd_ready=0 (the controller took the edge), then go to WAIT_DONE.
  - If sd_cmd_ready stays 1 for 4 cycles, go to GAP and retry from IDLE (edge lost). Do not ack.
- WAIT_DONE:
  - RD: on sd_dout_valid, capture cpu_dout, pulse cpu_ack, go to GAP.
  - WR: on sd_cmd_ready=1, pulse cpu_ack, go to GAP.
  - REF: on sd_cmd_ready=1, go to GAP with no ack.
  - sd_dout_valid outside a RD WAIT_DONE is ignored.
- GAP: sd_cs=0 for exactly one cycle so the next rising edge is visible, then go to IDLE.
- Latency:
  - cpu_ack for a read asserts 7–8 cycles after ISSUE.
  - cpu_ack for a write asserts 5–6 cycles after ISSUE.
  - At least 2 cycles between consecutive sd_cs rising edges.
- cpu_req handling:
  - cpu_req deasserted before ack: the cycle in flight still completes; the ack is dropped (cpu_ack not asserted).
  - cpu_ack never asserts while cpu_req=0.
- cpu_req and refresh_pending both high in IDLE: refresh first, then the CPU cycle.
- Reset mid-operation: synchronous return to reset values on the next edge, with sd_cs=0 that cycle.

Decomposition:
- Shared package sdram_pkg:
  - kind enum {KIND_RD, KIND_WR, KIND_REF}.
  - FSM state enum.
  - Constants SD_AW=21, SD_DW=32, EDGE_TIMEOUT=4.
- One sub-module, sdram_refresh_timer: counter plus pending flag, with clear input.

Test Plan:
- Refresh cadence: reset, sd_ready=1, no cpu_req, controller model responding. Expect sd_cs rising with sd_refresh=1 every 250 cycles ±8, and no cpu_ack.
- Read: cpu_addr=22'h000005, uds=lds=1, model returns sd_dout=32'hDEAD_BEEF. Expect sd_addr=21'h2, sd_ds=4'b1100, cpu_dout=16'hDEAD, a single cpu_ack pulse, and sd_cs low for 1 cycle after.
- Byte write: cpu_addr=22'h000004, uds=0, lds=1, cpu_din=16'h00A5. Expect sd_ds=4'b0001, sd_din=32'h00A5_00A5, sd_we=1, cpu_ack after sd_cmd_ready returns 1.
- Simultaneous: force refresh_pending and cpu_req (read) in the same IDLE cycle. Expect the refresh edge first, then a GAP, then the read edge, with exactly one cpu_ack.
- Lost edge: model keeps sd_cmd_ready=1 and ignores the first edge. Expect GAP then a reissue after 4 cycles, with no ack until the retried command completes.
- Reset during WAIT_DONE of a read: assert reset 1 cycle. Expect all outputs 0 next cycle, no cpu_ack, and a normal read after release.
